elevator_request_ctrl: RTL and testbench

Upstream request stage for the 3-floor elevator controller. It synchronizes and debounces the active-low floor-button and hall-call inputs and latches them as per-floor pending requests. It clears each request when the controller reports that floor as served, and presents the controller with a registered target floor and travel direction using collective (up/down sweep) scheduling.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/button_debounce.sv | 52 +++++
 rtl/elevator_request_ctrl.sv | 151 +++++++++++++++
 tb/tb_elevator_request_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request stage and the downstream controller:
// default sizing, floor index type and the sweep-direction state encoding.
package elevator_pkg;

   localparam int NFLOORS_DEFAULT         = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int FW_DEFAULT              = $clog2(NFLOORS_DEFAULT);

   typedef logic [FW_DEFAULT-1:0] floor_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } dir_state_e;

endpackage

// File: rtl/button_debounce.sv
// One active-low button line: 2-flop synchronizer, stability counter and debounced
// level, producing a single-cycle pulse when the debounced level rises.
import elevator_pkg::*;

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n,
   output logic rise
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          rise_r;
   logic [CW-1:0] cnt_r;
   logic          accept_s;

   // the level flips on the sample that completes the run of differing samples
   assign accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);

   // synchronizer, debounce counter, debounced level and rise pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         sync1_r <= ~raw_n;
         sync2_r <= sync1_r;
         rise_r  <= accept_s & ~level_r;
         if (sync2_r == level_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= ~level_r;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/elevator_request_ctrl.sv
// Request stage: debounced button/hall-call inputs latched as per-floor pending
// requests, with a registered collective-sweep target floor and direction.
import elevator_pkg::*;

module elevator_request_ctrl #(
   parameter int  NFLOORS         = NFLOORS_DEFAULT,
   parameter int  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   localparam int FW              = $clog2(NFLOORS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NFLOORS-1:0] fb_n,
   input  logic [NFLOORS-1:0] call_n,
   input  logic [FW-1:0]      cur_floor,
   input  logic               serve_valid,
   input  logic [FW-1:0]      serve_floor,
   output logic [NFLOORS-1:0] pending,
   output logic               req_valid,
   output logic [FW-1:0]      target_floor,
   output logic               dir_up
);

   logic [NFLOORS-1:0] fb_rise_s;
   logic [NFLOORS-1:0] call_rise_s;
   logic [NFLOORS-1:0] pending_r;
   logic [NFLOORS-1:0] pending_nxt_s;
   logic               req_valid_r;
   logic [FW-1:0]      target_r;
   logic [FW-1:0]      target_nxt_s;
   logic               dir_up_r;
   dir_state_e         state_r;
   dir_state_e         state_nxt_s;
   logic [FW-1:0]      up_tgt_s;
   logic [FW-1:0]      dn_tgt_s;
   logic               up_found_s;
   logic               dn_found_s;
   logic               above_s;
   logic               below_s;

   for (genvar g = 0; g < NFLOORS; g++) begin : g_lines
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fb (
         .clk   (clk),
         .reset (reset),
         .raw_n (fb_n[g]),
         .rise  (fb_rise_s[g])
      );
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_call (
         .clk   (clk),
         .reset (reset),
         .raw_n (call_n[g]),
         .rise  (call_rise_s[g])
      );
   end

   // clear the served floor first so a same-cycle press still wins
   always_comb begin
      pending_nxt_s = pending_r;
      if (serve_valid && (int'(serve_floor) < NFLOORS)) begin
         pending_nxt_s[serve_floor] = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
      pending_nxt_s = pending_nxt_s | fb_rise_s | call_rise_s;
   end

   // priority scans for the nearest pending floor on each side of the car
   always_comb begin
      up_tgt_s   = cur_floor;
      dn_tgt_s   = cur_floor;
      up_found_s = 1'b0;
      dn_found_s = 1'b0;
      above_s    = 1'b0;
      below_s    = 1'b0;
      for (int i = NFLOORS - 1; i >= 0; i--) begin
         if (pending_r[i] && (i >= int'(cur_floor))) begin
            up_tgt_s   = FW'(i);
            up_found_s = 1'b1;
         end else begin
            up_tgt_s = up_tgt_s;
         end
      end
      for (int i = 0; i < NFLOORS; i++) begin
         if (pending_r[i] && (i <= int'(cur_floor))) begin
            dn_tgt_s   = FW'(i);
            dn_found_s = 1'b1;
         end else begin
            dn_tgt_s = dn_tgt_s;
         end
         above_s = above_s | (pending_r[i] && (i > int'(cur_floor)));
         below_s = below_s | (pending_r[i] && (i < int'(cur_floor)));
      end
   end

   // direction FSM next state and target selection; an invalid floor freezes both
   always_comb begin
      state_nxt_s  = state_r;
      target_nxt_s = target_r;
      if (int'(cur_floor) >= NFLOORS) begin
         state_nxt_s  = state_r;
         target_nxt_s = target_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!(|pending_r))  state_nxt_s = ST_IDLE;
               else if (up_found_s) state_nxt_s = ST_UP;
               else                 state_nxt_s = ST_DOWN;
            end
            ST_UP: begin
               if (above_s)      state_nxt_s = ST_UP;
               else if (below_s) state_nxt_s = ST_DOWN;
               else              state_nxt_s = ST_IDLE;
            end
            ST_DOWN: begin
               if (below_s)      state_nxt_s = ST_DOWN;
               else if (above_s) state_nxt_s = ST_UP;
               else              state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
         endcase
         case (state_nxt_s)
            ST_UP:   target_nxt_s = up_tgt_s;
            ST_DOWN: target_nxt_s = dn_tgt_s;
            ST_IDLE: target_nxt_s = target_r;
            default: target_nxt_s = target_r;
         endcase
      end
   end

   // pending requests, FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_r   <= {NFLOORS{1'b0}};
         req_valid_r <= 1'b0;
         target_r    <= {FW{1'b0}};
         dir_up_r    <= 1'b1;
         state_r     <= ST_IDLE;
      end else begin
         pending_r   <= pending_nxt_s;
         req_valid_r <= |pending_r;
         target_r    <= target_nxt_s;
         dir_up_r    <= (state_nxt_s != ST_DOWN);
         state_r     <= state_nxt_s;
      end
   end

   assign pending      = pending_r;
   assign req_valid    = req_valid_r;
   assign target_floor = target_r;
   assign dir_up       = dir_up_r;

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// Directed self-checking bench for elevator_request_ctrl with hand-computed
// expectations for debounce latency, sweep scheduling, clear priority and reset.
module tb_elevator_request_ctrl;

   logic       clk;
   logic       reset;
   logic [2:0] fb_n;
   logic [2:0] call_n;
   logic [1:0] cur_floor;
   logic       serve_valid;
   logic [1:0] serve_floor;
   logic [2:0] pending;
   logic       req_valid;
   logic [1:0] target_floor;
   logic       dir_up;

   int checks = 0;
   int errors = 0;

   elevator_request_ctrl #(.NFLOORS(3), .DEBOUNCE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .fb_n         (fb_n),
      .call_n       (call_n),
      .cur_floor    (cur_floor),
      .serve_valid  (serve_valid),
      .serve_floor  (serve_floor),
      .pending      (pending),
      .req_valid    (req_valid),
      .target_floor (target_floor),
      .dir_up       (dir_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      fb_n        = 3'b111;
      call_n      = 3'b111;
      cur_floor   = 2'd0;
      serve_valid = 1'b0;
      serve_floor = 2'd0;
      tick(2);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_req_valid", 32'(req_valid), 32'h0);
      chk("rst_target", 32'(target_floor), 32'h0);
      chk("rst_dir_up", 32'(dir_up), 32'h1);
      reset = 1'b0;

      // 3-cycle glitch on fb_n[2] must be rejected
      fb_n = 3'b011;
      tick(3);
      fb_n = 3'b111;
      tick(8);
      chk("glitch_pending", 32'(pending), 32'h0);

      // held press: visible after the 7th edge (edge index 6)
      fb_n = 3'b011;
      tick(6);
      chk("press_edge5", 32'(pending), 32'h0);
      tick(1);
      chk("press_edge6", 32'(pending), 32'h4);
      tick(1);
      chk("press_req_valid", 32'(req_valid), 32'h1);
      chk("press_target", 32'(target_floor), 32'h2);
      chk("press_dir_up", 32'(dir_up), 32'h1);
      serve_valid = 1'b1;
      serve_floor = 2'd2;
      tick(1);
      serve_valid = 1'b0;
      chk("held_clear", 32'(pending), 32'h0);
      tick(3);
      chk("held_no_second", 32'(pending), 32'h0);
      chk("held_req_valid", 32'(req_valid), 32'h0);
      fb_n = 3'b111;
      tick(8);

      // sweep up: floors 1 and 2 requested from floor 0
      call_n = 3'b101;
      fb_n   = 3'b011;
      tick(7);
      chk("sweep_pending", 32'(pending), 32'h6);
      tick(1);
      chk("sweep_target1", 32'(target_floor), 32'h1);
      chk("sweep_dir1", 32'(dir_up), 32'h1);
      chk("sweep_req_valid", 32'(req_valid), 32'h1);
      call_n      = 3'b111;
      fb_n        = 3'b111;
      serve_valid = 1'b1;
      serve_floor = 2'd1;
      cur_floor   = 2'd1;
      tick(1);
      serve_valid = 1'b0;
      chk("sweep_serve1", 32'(pending), 32'h4);
      tick(1);
      chk("sweep_target2", 32'(target_floor), 32'h2);
      chk("sweep_dir2", 32'(dir_up), 32'h1);

      // reversal: car at floor 2, only floor 0 requested
      cur_floor   = 2'd2;
      serve_valid = 1'b1;
      serve_floor = 2'd2;
      tick(1);
      serve_valid = 1'b0;
      chk("rev_clear2", 32'(pending), 32'h0);
      call_n = 3'b110;
      tick(7);
      chk("rev_pending", 32'(pending), 32'h1);
      call_n = 3'b111;
      tick(1);
      chk("rev_dir_down", 32'(dir_up), 32'h0);
      chk("rev_target0", 32'(target_floor), 32'h0);
      chk("rev_req_valid", 32'(req_valid), 32'h1);
      serve_valid = 1'b1;
      serve_floor = 2'd0;
      cur_floor   = 2'd0;
      tick(1);
      serve_valid = 1'b0;
      chk("rev_serve0", 32'(pending), 32'h0);
      chk("rev_req_lag", 32'(req_valid), 32'h1);
      tick(1);
      chk("rev_req_fall", 32'(req_valid), 32'h0);
      chk("rev_idle_dir", 32'(dir_up), 32'h1);

      // rise on floor 1 in the same cycle as serving floor 1: set wins
      fb_n = 3'b101;
      tick(6);
      chk("sim_before", 32'(pending), 32'h0);
      serve_valid = 1'b1;
      serve_floor = 2'd1;
      tick(1);
      serve_valid = 1'b0;
      chk("sim_set_wins", 32'(pending), 32'h2);
      serve_valid = 1'b1;
      serve_floor = 2'd3;
      tick(1);
      serve_valid = 1'b0;
      chk("serve_out_of_range", 32'(pending), 32'h2);

      // all floors pending while sweeping up, then reset mid-operation
      fb_n = 3'b010;
      tick(7);
      chk("mid_pending", 32'(pending), 32'h7);
      chk("mid_target", 32'(target_floor), 32'h1);
      chk("mid_dir_up", 32'(dir_up), 32'h1);
      chk("mid_req_valid", 32'(req_valid), 32'h1);
      reset = 1'b1;
      fb_n  = 3'b111;
      tick(1);
      chk("mid_rst_pending", 32'(pending), 32'h0);
      chk("mid_rst_req_valid", 32'(req_valid), 32'h0);
      chk("mid_rst_target", 32'(target_floor), 32'h0);
      chk("mid_rst_dir_up", 32'(dir_up), 32'h1);
      reset = 1'b0;
      tick(8);
      chk("post_rst_pending", 32'(pending), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
